// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution write-back path.
package conv_pkg;

    localparam int ADDR_W = 28;
    localparam int BIAS_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ADDR,
        WRITE
    } wr_state_t;

    // Destination of one filter word: pixel base plus per-filter offset, wrapping at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] dest_addr(
        input logic [ADDR_W-1:0] prim,
        input logic [BIAS_W-1:0] bias
    );
        return prim + ADDR_W'(bias);
    endfunction

endpackage

// File: rtl/conv_wr_fifo.sv
// Small first-word-fall-through FIFO buffering result words ahead of the write engine.
module conv_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; clear empties the buffer without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/conv_wr_ctrl.sv
// Write-back controller: buffers result words, fetches a destination per word, writes with hold-until-ack.
module conv_wr_ctrl import conv_pkg::*; #(
    parameter int word_len     = 32,
    parameter int channel_size = 64,
    parameter int fifo_depth   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 conv_start,
    input  logic                 res_valid,
    input  logic [word_len-1:0]  res_data,
    output logic                 res_ready,
    output logic                 CwbCc_addrRq,
    input  logic [ADDR_W-1:0]    CcCwb_primAddr,
    input  logic                 CcCwb_primAddrEn,
    input  logic [BIAS_W-1:0]    CcCwb_primAddrBias,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [word_len-1:0]  mem_wr_data,
    input  logic                 mem_wr_ack,
    output logic                 pix_done
);

    localparam int CNT_W  = (channel_size > 1) ? $clog2(channel_size) : 1;
    localparam int FCNT_W = $clog2(fifo_depth) + 1;

    wr_state_t             state_reg;
    wr_state_t             state_next;
    logic [CNT_W-1:0]      word_cnt_reg;
    logic                  pix_done_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [word_len-1:0]   data_reg;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [word_len-1:0]   fifo_head;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  push;
    logic                  ack_take;
    logic                  last_word;

    assign push      = res_valid && !fifo_full;
    assign ack_take  = (state_reg == WRITE) && mem_wr_ack;
    assign last_word = (word_cnt_reg == CNT_W'(channel_size - 1));

    conv_wr_fifo #(
        .WIDTH (word_len),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (!conv_start),
        .push      (push),
        .push_data (res_data),
        .pop       (ack_take),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state decode; the ack cycle looks past its own pop (and any same-cycle push) to pick REQ or IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (!fifo_empty) state_next = REQ;
            REQ:       state_next = WAIT_ADDR;
            WAIT_ADDR: if (CcCwb_primAddrEn) state_next = WRITE;
            WRITE: begin
                if (mem_wr_ack) begin
                    state_next = ((fifo_count > FCNT_W'(1)) || push) ? REQ : IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // State register; dropping conv_start abandons whatever is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           state_reg <= IDLE;
        else if (!conv_start) state_reg <= IDLE;
        else                  state_reg <= state_next;
    end

    // Write address/data capture, per-pixel word counting and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            data_reg     <= '0;
            word_cnt_reg <= '0;
            pix_done_reg <= 1'b0;
        end else if (!conv_start) begin
            addr_reg     <= '0;
            data_reg     <= '0;
            word_cnt_reg <= '0;
            pix_done_reg <= 1'b0;
        end else begin
            pix_done_reg <= 1'b0;
            if ((state_reg == WAIT_ADDR) && CcCwb_primAddrEn) begin
                addr_reg <= dest_addr(CcCwb_primAddr, CcCwb_primAddrBias);
                data_reg <= fifo_head;
            end
            if (ack_take) begin
                word_cnt_reg <= last_word ? '0 : word_cnt_reg + 1'b1;
                pix_done_reg <= last_word;
            end
        end
    end

    assign res_ready    = !fifo_full;
    assign CwbCc_addrRq = (state_reg == REQ);
    assign mem_wr_en    = (state_reg == WRITE);
    assign mem_wr_addr  = addr_reg;
    assign mem_wr_data  = data_reg;
    assign pix_done     = pix_done_reg;

endmodule
